// File: rtl/rst_seq_pkg.sv
// Shared state and reset-cause encodings for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        IDLE_ASSERT = 2'd0,
        HOLD        = 2'd1,
        RELEASE     = 2'd2,
        RUN         = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        POR = 2'd0,
        EXT = 2'd1,
        SW  = 2'd2
    } cause_t;

endpackage

// File: rtl/rst_sync_filter.sv
// Synchronises the active-low external reset request and glitch-filters it
// into an active-high request req_f that only moves after FILTER stable edges.
module rst_sync_filter
    import rst_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER      = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic ext_rst_n,
    output logic req_f
);

    localparam int unsigned FCW = (FILTER > 1) ? $clog2(FILTER) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FCW-1:0]         r_fcnt;
    logic                   r_req_f;
    logic                   w_req_s;

    assign w_req_s = ~r_sync[SYNC_STAGES-1];
    assign req_f   = r_req_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_fcnt  <= '0;
            r_req_f <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ext_rst_n};
            // any edge where s agrees with f restarts the stability count
            if (w_req_s != r_req_f) begin
                if (r_fcnt == FCW'(FILTER - 1)) begin
                    r_req_f <= w_req_s;
                    r_fcnt  <= '0;
                end else begin
                    r_fcnt <= r_fcnt + FCW'(1);
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: holds all domains in reset after a filtered request clears,
// then releases channels one by one with a fixed stagger and reports the cause.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER      = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGGER     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_rst_n,
    input  logic              sw_rst,
    input  logic [NUM_CH-1:0] ch_hold,
    output logic [NUM_CH-1:0] rst_out,
    output logic              rst_done,
    output logic [1:0]        state,
    output logic [1:0]        rst_cause
);

    localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned SCW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t            r_state, w_state_nxt;
    cause_t            r_cause, w_cause_nxt;
    logic [HCW-1:0]    r_hcnt, w_hcnt_nxt;
    logic [SCW-1:0]    r_scnt, w_scnt_nxt;
    logic [CHW-1:0]    r_ch, w_ch_nxt;
    logic [NUM_CH-1:0] r_seq, w_seq_nxt;
    logic [NUM_CH-1:0] r_rst_out;
    logic              w_req_f;

    rst_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER      (FILTER)
    ) u_sync_filter (
        .clk       (clk),
        .rst       (rst),
        .ext_rst_n (ext_rst_n),
        .req_f     (w_req_f)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE_ASSERT;
            r_cause   <= POR;
            r_hcnt    <= '0;
            r_scnt    <= '0;
            r_ch      <= '0;
            r_seq     <= '1;
            r_rst_out <= '1;
        end else begin
            r_state   <= w_state_nxt;
            r_cause   <= w_cause_nxt;
            r_hcnt    <= w_hcnt_nxt;
            r_scnt    <= w_scnt_nxt;
            r_ch      <= w_ch_nxt;
            r_seq     <= w_seq_nxt;
            // built from next-state sequencer bits so ch_hold is the only one-edge-late term
            r_rst_out <= w_seq_nxt | ch_hold;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_hcnt_nxt  = r_hcnt;
        w_scnt_nxt  = r_scnt;
        w_ch_nxt    = r_ch;
        w_seq_nxt   = r_seq;

        if (r_state != IDLE_ASSERT && (w_req_f || sw_rst)) begin
            w_state_nxt = IDLE_ASSERT;
            w_cause_nxt = w_req_f ? EXT : SW;
            w_hcnt_nxt  = '0;
            w_scnt_nxt  = '0;
            w_ch_nxt    = '0;
            w_seq_nxt   = '1;
        end else begin
            case (r_state)
                IDLE_ASSERT: begin
                    w_seq_nxt = '1;
                    if (sw_rst) begin
                        w_cause_nxt = SW;
                    end
                    if (!w_req_f) begin
                        w_state_nxt = HOLD;
                        w_hcnt_nxt  = '0;
                    end
                end
                HOLD: begin
                    if (r_hcnt == HCW'(HOLD_CYCLES - 1)) begin
                        w_seq_nxt[0] = 1'b0;
                        w_scnt_nxt   = '0;
                        w_ch_nxt     = CHW'(1);
                        w_state_nxt  = (NUM_CH == 1) ? RUN : RELEASE;
                    end else begin
                        w_hcnt_nxt = r_hcnt + HCW'(1);
                    end
                end
                RELEASE: begin
                    if (r_scnt == SCW'(STAGGER - 1)) begin
                        w_seq_nxt[r_ch] = 1'b0;
                        w_scnt_nxt      = '0;
                        if (r_ch == CHW'(NUM_CH - 1)) begin
                            w_state_nxt = RUN;
                        end else begin
                            w_ch_nxt = r_ch + CHW'(1);
                        end
                    end else begin
                        w_scnt_nxt = r_scnt + SCW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rst_out   = r_rst_out;
    assign rst_done  = (r_state == RUN);
    assign state     = r_state;
    assign rst_cause = r_cause;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer at default parameters; expected timing
// derived from the edge numbering of the power-on sequence.
module tb_rst_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ext_rst_n;
    logic       sw_rst;
    logic [3:0] ch_hold;
    logic [3:0] rst_out;
    logic       rst_done;
    logic [1:0] state;
    logic [1:0] rst_cause;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rst_sequencer #(
        .NUM_CH      (4),
        .SYNC_STAGES (2),
        .FILTER      (3),
        .HOLD_CYCLES (16),
        .STAGGER     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ext_rst_n (ext_rst_n),
        .sw_rst    (sw_rst),
        .ch_hold   (ch_hold),
        .rst_out   (rst_out),
        .rst_done  (rst_done),
        .state     (state),
        .rst_cause (rst_cause)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // channel i is released at edge 22 + 4*i of the power-on sequence
    function automatic logic [3:0] exp_seq(input int n);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (n < 22 + 4 * i);
        return v;
    endfunction

    function automatic logic [1:0] exp_state(input int n);
        if (n < 6)  return 2'd0;
        if (n < 22) return 2'd1;
        if (n < 34) return 2'd2;
        return 2'd3;
    endfunction

    task automatic check_seq(input logic [3:0] hold, input int n_first, input int n_last);
        for (int n = n_first; n <= n_last; n++) begin
            tick();
            chk($sformatf("rst_out@%0d", n), 32'(rst_out), 32'(exp_seq(n) | hold));
            chk($sformatf("state@%0d", n), 32'(state), 32'(exp_state(n)));
            chk($sformatf("done@%0d", n), 32'(rst_done), 32'(n >= 34));
        end
    endtask

    initial begin
        rst       = 1'b1;
        ext_rst_n = 1'b1;
        sw_rst    = 1'b0;
        ch_hold   = 4'b0000;
        repeat (5) tick();
        chk("reset_rst_out", 32'(rst_out), 32'hF);
        chk("reset_done", 32'(rst_done), 32'd0);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_cause", 32'(rst_cause), 32'd0);

        // power-on sequence
        rst = 1'b0;
        check_seq(4'b0000, 1, 34);
        chk("por_cause", 32'(rst_cause), 32'd0);

        // 2-cycle ext glitch is filtered out
        ext_rst_n = 1'b0;
        tick();
        tick();
        ext_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("glitch_rst_out", 32'(rst_out), 32'h0);
            chk("glitch_state", 32'(state), 32'd3);
            chk("glitch_done", 32'(rst_done), 32'd1);
        end

        // 10-cycle ext request restarts the sequence
        ext_rst_n = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 5) begin
                chk("ext_e5_state", 32'(state), 32'd3);
                chk("ext_e5_rst_out", 32'(rst_out), 32'h0);
            end
            if (k == 6) begin
                chk("ext_e6_rst_out", 32'(rst_out), 32'hF);
                chk("ext_e6_done", 32'(rst_done), 32'd0);
                chk("ext_e6_state", 32'(state), 32'd0);
                chk("ext_e6_cause", 32'(rst_cause), 32'd1);
            end
        end
        ext_rst_n = 1'b1;
        check_seq(4'b0000, 1, 27);

        // sw_rst in RELEASE after channel 1 is out
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        chk("sw_rst_out", 32'(rst_out), 32'hF);
        chk("sw_state", 32'(state), 32'd0);
        chk("sw_cause", 32'(rst_cause), 32'd2);
        chk("sw_done", 32'(rst_done), 32'd0);
        tick();
        chk("sw_hold_state", 32'(state), 32'd1);
        chk("sw_hold_rst_out", 32'(rst_out), 32'hF);
        check_seq(4'b0000, 7, 34);

        // sw_rst from RUN, then rst pulse during HOLD
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        chk("sw2_state", 32'(state), 32'd0);
        chk("sw2_cause", 32'(rst_cause), 32'd2);
        tick();
        chk("sw2_hold_state", 32'(state), 32'd1);
        check_seq(4'b0000, 7, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstp_rst_out", 32'(rst_out), 32'hF);
        chk("rstp_state", 32'(state), 32'd0);
        chk("rstp_done", 32'(rst_done), 32'd0);
        chk("rstp_cause", 32'(rst_cause), 32'd0);
        check_seq(4'b0000, 1, 34);

        // ch_hold keeps channel 2 in reset without stalling the FSM
        rst     = 1'b1;
        ch_hold = 4'b0100;
        tick();
        tick();
        rst = 1'b0;
        check_seq(4'b0100, 1, 34);
        ch_hold = 4'b0000;
        tick();
        chk("hold_drop_rst_out", 32'(rst_out), 32'h0);
        chk("hold_drop_state", 32'(state), 32'd3);
        chk("hold_drop_done", 32'(rst_done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
